// File: rtl/receiver_expand_if.sv
// Handshake bundle for the GGM receiver expander: start/alpha, co-path
// stream, external PRG port, leaf output stream and status.
interface receiver_expand_if #(parameter int D = 3);
    logic           start;
    logic [D-1:0]   alpha;
    logic           cw_valid;
    logic [127:0]   cw_data;
    logic           cw_ready;
    logic           prg_req;
    logic [127:0]   prg_seed;
    logic           prg_ack;
    logic [127:0]   prg_left;
    logic [127:0]   prg_right;
    logic           out_valid;
    logic           out_ready;
    logic [D-1:0]   out_index;
    logic [127:0]   out_data;
    logic           out_punct;
    logic           busy;
    logic           done;

    modport master (
        output start, alpha, cw_valid, cw_data, prg_ack, prg_left, prg_right, out_ready,
        input  cw_ready, prg_req, prg_seed, out_valid, out_index, out_data, out_punct, busy, done
    );

    modport slave (
        input  start, alpha, cw_valid, cw_data, prg_ack, prg_left, prg_right, out_ready,
        output cw_ready, prg_req, prg_seed, out_valid, out_index, out_data, out_punct, busy, done
    );
endinterface

// File: rtl/receiver_expand.sv
// Punctured GGM tree reconstruction: rebuilds all 2**D leaves except alpha
// from the co-path seeds, expanding in place level by level with an external PRG.
module receiver_expand #(
    parameter int D = 3
) (
    input logic              clk,
    input logic              rst,
    receiver_expand_if.slave bus
);

    localparam int             N    = 1 << D;
    localparam int             LW   = $clog2(D + 1);
    localparam logic [D-1:0]   ONE  = D'(1);
    localparam logic [D-1:0]   LAST = D'(N - 1);

    typedef enum logic [2:0] {
        IDLE, GET_CW, EXPAND, PRG_WAIT, NEXT_LVL, OUTPUT, DONE
    } state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   level, level_nxt;
    logic [D-1:0]    idx, idx_nxt;
    logic [D-1:0]    out_idx, out_idx_nxt;
    logic [D-1:0]    alpha_q, alpha_nxt;
    logic [D-1:0]    path_cur, path_par;
    logic [127:0]    cw_q;
    logic            cw_ld;
    logic [127:0]    node [N];
    logic            wr_en;
    logic [D-1:0]    wr_lo_addr, wr_hi_addr;
    logic [127:0]    wr_lo_data, wr_hi_data;

    // At level 1 the shift equals D, so the path parent is node 0.
    assign path_cur = alpha_q >> (D - int'(level));
    assign path_par = alpha_q >> (D - int'(level) + 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            level   <= '0;
            idx     <= '0;
            out_idx <= '0;
            alpha_q <= '0;
        end else begin
            state   <= state_nxt;
            level   <= level_nxt;
            idx     <= idx_nxt;
            out_idx <= out_idx_nxt;
            alpha_q <= alpha_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        level_nxt   = level;
        idx_nxt     = idx;
        out_idx_nxt = out_idx;
        alpha_nxt   = alpha_q;
        cw_ld       = 1'b0;
        wr_en       = 1'b0;
        wr_lo_addr  = '0;
        wr_hi_addr  = '0;
        wr_lo_data  = '0;
        wr_hi_data  = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    alpha_nxt = bus.alpha;
                    level_nxt = LW'(1);
                    state_nxt = GET_CW;
                end
            end
            GET_CW: begin
                if (bus.cw_valid) begin
                    cw_ld     = 1'b1;
                    idx_nxt   = (ONE << (level - LW'(1))) - ONE;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (idx == path_par) begin
                    // Path node is punctured: its sibling takes the co-path seed.
                    wr_en      = 1'b1;
                    wr_lo_addr = path_cur ^ ONE;
                    wr_lo_data = cw_q;
                    wr_hi_addr = path_cur;
                    wr_hi_data = '0;
                    if (idx == '0) state_nxt = NEXT_LVL;
                    else           idx_nxt   = idx - ONE;
                end else begin
                    state_nxt = PRG_WAIT;
                end
            end
            PRG_WAIT: begin
                if (bus.prg_ack) begin
                    // Descending i keeps 2i/2i+1 clear of parents still to expand.
                    wr_en      = 1'b1;
                    wr_lo_addr = idx << 1;
                    wr_lo_data = bus.prg_left;
                    wr_hi_addr = (idx << 1) | ONE;
                    wr_hi_data = bus.prg_right;
                    if (idx == '0) begin
                        state_nxt = NEXT_LVL;
                    end else begin
                        idx_nxt   = idx - ONE;
                        state_nxt = EXPAND;
                    end
                end
            end
            NEXT_LVL: begin
                if (level == LW'(D)) begin
                    out_idx_nxt = '0;
                    state_nxt   = OUTPUT;
                end else begin
                    level_nxt = level + LW'(1);
                    state_nxt = GET_CW;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    if (out_idx == LAST) state_nxt   = DONE;
                    else                 out_idx_nxt = out_idx + ONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cw_ld) cw_q <= bus.cw_data;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            node[wr_lo_addr] <= wr_lo_data;
            node[wr_hi_addr] <= wr_hi_data;
        end
    end

    // Data outputs are gated by state, so unreset array contents never leak.
    assign bus.cw_ready  = (state == GET_CW);
    assign bus.prg_req   = (state == PRG_WAIT);
    assign bus.prg_seed  = (state == PRG_WAIT) ? node[idx] : '0;
    assign bus.out_valid = (state == OUTPUT);
    assign bus.out_index = out_idx;
    assign bus.out_data  = (state == OUTPUT) ? node[out_idx] : '0;
    assign bus.out_punct = (state == OUTPUT) && (out_idx == alpha_q);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_receiver_expand.sv
// Directed bench for receiver_expand (D=3) with an XOR PRG model:
// left = seed ^ 1, right = seed ^ 2.
module tb_receiver_expand;

    localparam int D = 3;
    localparam int N = 8;

    localparam logic [127:0] A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] B = 128'h1111_2222_3333_4444_5555_6666_7777_8880;
    localparam logic [127:0] C = 128'hdead_beef_cafe_f00d_0bad_c0de_face_b00c;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    receiver_expand_if #(.D(D)) bus ();
    receiver_expand #(.D(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [127:0] cw_vec [3];
    logic [127:0] got_data [N];
    logic         got_punct [N];
    int           got_cnt, order_err, stall_err, seed_err, prg_cnt, done_cnt;
    bit           timed_out;

    // Independent GGM leaf model: seed from the level where j leaves the alpha path.
    function automatic logic [127:0] model_leaf(int a, int j);
        logic [127:0] s;
        if (j == a) return '0;
        for (int l = 1; l <= D; l++) begin
            if ((j >> (D - l)) != (a >> (D - l))) begin
                s = cw_vec[l-1];
                for (int k = l + 1; k <= D; k++)
                    s = (((j >> (D - k)) & 1) != 0) ? (s ^ 128'h2) : (s ^ 128'h1);
                return s;
            end
        end
        return '0;
    endfunction

    task automatic run_rec(input int a, input int dly, input bit rnd_dly, input bit gaps,
                           input bit rnd_ready, input bit poke_start, input bit stop_lvl3,
                           output bit stopped);
        int           cwk = 0;
        bit           cw_take, req_act = 0, stalled = 0, rdy;
        int           wait_c = 0;
        logic [127:0] req_seed = '0, h_data = '0;
        logic [D-1:0] h_idx = '0;
        logic         h_p = 1'b0;
        stopped = 0;
        got_cnt = 0; order_err = 0; stall_err = 0; seed_err = 0;
        prg_cnt = 0; done_cnt = 0; timed_out = 0;
        for (int j = 0; j < N; j++) begin got_data[j] = 'x; got_punct[j] = 1'bx; end
        bus.alpha = D'(a); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.done) begin
                done_cnt++;
                bus.start = 0; bus.cw_valid = 0; bus.prg_ack = 0; bus.out_ready = 0;
                @(posedge clk); #1;
                return;
            end
            if (stop_lvl3 && cwk == 3 && bus.prg_req) begin
                bus.prg_ack = 0; bus.cw_valid = 0;
                stopped = 1;
                return;
            end
            if (poke_start) begin
                bus.start = (cyc % 9 == 3);
                bus.alpha = D'($urandom);
            end
            cw_take = bus.cw_ready && !(gaps && $urandom_range(0, 1) == 0);
            if (cw_take) begin
                bus.cw_valid = 1'b1;
                bus.cw_data  = cw_vec[(cwk < 3) ? cwk : 0];
            end else begin
                bus.cw_valid = (gaps && !bus.cw_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.cw_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.prg_ack = 1'b0;
            if (bus.prg_req) begin
                if (!req_act) begin
                    req_act  = 1;
                    req_seed = bus.prg_seed;
                    wait_c   = rnd_dly ? int'($urandom_range(0, 5)) : dly;
                end else if (bus.prg_seed !== req_seed) begin
                    seed_err++;
                end
                if (wait_c == 0) begin
                    bus.prg_ack   = 1'b1;
                    bus.prg_left  = req_seed ^ 128'h1;
                    bus.prg_right = req_seed ^ 128'h2;
                    prg_cnt++;
                    req_act = 0;
                end else begin
                    wait_c--;
                end
            end else begin
                req_act       = 0;
                bus.prg_ack   = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.prg_left  = {$urandom, $urandom, $urandom, $urandom};
                bus.prg_right = {$urandom, $urandom, $urandom, $urandom};
            end
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid) begin
                if (stalled && (bus.out_index !== h_idx || bus.out_data !== h_data ||
                                bus.out_punct !== h_p))
                    stall_err++;
                if (rdy) begin
                    if (int'(bus.out_index) != got_cnt) order_err++;
                    got_data[bus.out_index]  = bus.out_data;
                    got_punct[bus.out_index] = bus.out_punct;
                    got_cnt++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    h_idx = bus.out_index; h_data = bus.out_data; h_p = bus.out_punct;
                end
            end else begin
                stalled = 0;
            end
            bus.out_ready = rdy;
            @(posedge clk); #1;
            if (cw_take) cwk++;
        end
        timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.cw_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cw_ready got=%b exp=0", bus.cw_ready); end
        n_cmp++; if (bus.prg_req !== 1'b0) begin n_fail++; $display("FAIL reset_prg_req got=%b exp=0", bus.prg_req); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_punct !== 1'b0) begin n_fail++; $display("FAIL reset_out_punct got=%b exp=0", bus.out_punct); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.out_index !== 3'd0) begin n_fail++; $display("FAIL reset_out_index got=%0d exp=0", bus.out_index); end
        n_cmp++; if (bus.out_data !== 128'd0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        n_cmp++; if (bus.prg_seed !== 128'd0) begin n_fail++; $display("FAIL reset_prg_seed got=%h exp=0", bus.prg_seed); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [127:0] exp_leaf [N];
        bit st;
        exp_leaf = '{A, A ^ 128'h3, A ^ 128'h3, A, C, 128'h0, B ^ 128'h1, B ^ 128'h2};
        cw_vec = '{A, B, C};
        run_rec(5, 1, 0, 0, 0, 0, 0, st);
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (got_data[j] !== exp_leaf[j]) begin n_fail++; $display("FAIL basic_leaf%0d got=%h exp=%h", j, got_data[j], exp_leaf[j]); end
            n_cmp++;
            if (got_punct[j] !== (j == 5)) begin n_fail++; $display("FAIL basic_punct%0d got=%b exp=%b", j, got_punct[j], j == 5); end
        end
        n_cmp++; if (prg_cnt != 4) begin n_fail++; $display("FAIL basic_prg_cnt got=%0d exp=4", prg_cnt); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
        n_cmp++; if (got_cnt != N) begin n_fail++; $display("FAIL basic_leaf_cnt got=%0d exp=%0d", got_cnt, N); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_idle busy=%b done=%b exp=0/0", bus.busy, bus.done); end
    endtask

    task automatic test_alpha_edges();
        int alist [2] = '{0, 7};
        bit st;
        cw_vec = '{128'h5555_0000_aaaa_0000_1234_5678_9abc_def0, 128'h77, 128'hf0f0_0000_0000_0000_0000_0000_0000_0f0f};
        foreach (alist[n]) begin
            run_rec(alist[n], 0, 0, 0, 0, 0, 0, st);
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (got_data[j] !== model_leaf(alist[n], j)) begin n_fail++; $display("FAIL edge_a%0d_leaf%0d got=%h exp=%h", alist[n], j, got_data[j], model_leaf(alist[n], j)); end
                n_cmp++;
                if (got_punct[j] !== (j == alist[n])) begin n_fail++; $display("FAIL edge_a%0d_punct%0d got=%b exp=%b", alist[n], j, got_punct[j], j == alist[n]); end
            end
            n_cmp++; if (prg_cnt != 4) begin n_fail++; $display("FAIL edge_a%0d_prg_cnt got=%0d exp=4", alist[n], prg_cnt); end
            n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL edge_a%0d_done got=%0d exp=1", alist[n], done_cnt); end
        end
    endtask

    task automatic test_random_delays();
        bit st;
        cw_vec = '{A, B, C};
        for (int r = 0; r < 3; r++) begin
            run_rec(5, 0, 1, 1, 0, 0, 0, st);
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (got_data[j] !== model_leaf(5, j)) begin n_fail++; $display("FAIL rnd%0d_leaf%0d got=%h exp=%h", r, j, got_data[j], model_leaf(5, j)); end
            end
            n_cmp++; if (seed_err != 0) begin n_fail++; $display("FAIL rnd%0d_seed_stable changes=%0d exp=0", r, seed_err); end
            n_cmp++; if (prg_cnt != 4) begin n_fail++; $display("FAIL rnd%0d_prg_cnt got=%0d exp=4", r, prg_cnt); end
        end
    endtask

    task automatic test_backpressure();
        bit st;
        cw_vec = '{C, A, B};
        run_rec(6, 1, 0, 0, 1, 0, 0, st);
        n_cmp++; if (got_cnt != N) begin n_fail++; $display("FAIL bp_leaf_cnt got=%0d exp=%0d", got_cnt, N); end
        n_cmp++; if (order_err != 0) begin n_fail++; $display("FAIL bp_order errors=%0d exp=0", order_err); end
        n_cmp++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stall_hold errors=%0d exp=0", stall_err); end
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (got_data[j] !== model_leaf(6, j)) begin n_fail++; $display("FAIL bp_leaf%0d got=%h exp=%h", j, got_data[j], model_leaf(6, j)); end
        end
    endtask

    task automatic test_reset_mid();
        bit st;
        cw_vec = '{B, C, A};
        run_rec(5, 2, 0, 0, 0, 0, 1, st);
        n_cmp++; if (st !== 1'b1) begin n_fail++; $display("FAIL mid_reach_lvl3 got=%b exp=1", st); end
        n_cmp++; if (bus.prg_req !== 1'b1) begin n_fail++; $display("FAIL mid_prg_req_before got=%b exp=1", bus.prg_req); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.prg_req !== 1'b0) begin n_fail++; $display("FAIL mid_prg_req got=%b exp=0", bus.prg_req); end
        n_cmp++; if (bus.prg_seed !== 128'd0) begin n_fail++; $display("FAIL mid_prg_seed got=%h exp=0", bus.prg_seed); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 128'd0) begin n_fail++; $display("FAIL mid_out got=%b/%h exp=0/0", bus.out_valid, bus.out_data); end
        n_cmp++; if (bus.cw_ready !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_ctrl cw_ready=%b done=%b exp=0/0", bus.cw_ready, bus.done); end
        @(posedge clk); #1;
        rst = 1'b1;
        cw_vec = '{C, B, A};
        run_rec(2, 1, 0, 0, 0, 0, 0, st);
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (got_data[j] !== model_leaf(2, j)) begin n_fail++; $display("FAIL mid_rerun_leaf%0d got=%h exp=%h", j, got_data[j], model_leaf(2, j)); end
            n_cmp++;
            if (got_punct[j] !== (j == 2)) begin n_fail++; $display("FAIL mid_rerun_punct%0d got=%b exp=%b", j, got_punct[j], j == 2); end
        end
        n_cmp++; if (prg_cnt != 4) begin n_fail++; $display("FAIL mid_rerun_prg_cnt got=%0d exp=4", prg_cnt); end
    endtask

    task automatic test_start_busy();
        bit st;
        cw_vec = '{A ^ B, B ^ C, C ^ A};
        run_rec(3, 1, 0, 0, 0, 1, 0, st);
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (got_data[j] !== model_leaf(3, j)) begin n_fail++; $display("FAIL busy_leaf%0d got=%h exp=%h", j, got_data[j], model_leaf(3, j)); end
            n_cmp++;
            if (got_punct[j] !== (j == 3)) begin n_fail++; $display("FAIL busy_punct%0d got=%b exp=%b", j, got_punct[j], j == 3); end
        end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done got=%0d exp=1", done_cnt); end
        n_cmp++; if (prg_cnt != 4) begin n_fail++; $display("FAIL busy_prg_cnt got=%0d exp=4", prg_cnt); end
    endtask

    initial begin
        bus.start = 0; bus.alpha = '0; bus.cw_valid = 0; bus.cw_data = '0;
        bus.prg_ack = 0; bus.prg_left = '0; bus.prg_right = '0; bus.out_ready = 0;
        test_reset();
        test_basic();
        test_alpha_edges();
        test_random_delays();
        test_backpressure();
        test_reset_mid();
        test_start_busy();
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL final_timeout got=1 exp=0"); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
